alu_pipe_stage: RTL and testbench

- Registered, handshaked execution wrapper around the combinational `alu` (ops ADD/SUB/AND/OR/XOR/SLL/SRL/SRA; flags overflow, carry, zero, negative).
- Accepts commands `{a, b, op}` on a valid/ready input and returns results plus a flag vector on a valid/ready output.
- Two-deep pipeline, full throughput of one op per cycle.
- Also keeps sticky flags and a completed-op counter for the downstream controller.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 57 +++++
 rtl/alu_pipe_stage.sv | 121 ++++++++++++
 tb/tb_alu_pipe_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and flag definitions for the alu and its pipeline wrapper
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam int FLAG_W = 4;
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational alu: add/sub/logic/shift with overflow, carry, zero, negative flags
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        op,
    output logic [WIDTH-1:0]  y,
    output logic [FLAG_W-1:0] flags
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SH_MAX = WIDTH'(WIDTH - 1);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sh;
    logic             carry;
    logic             ovf;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        // Oversized shift amounts clamp to the widest meaningful shift.
        sh    = (b > SH_MAX) ? SH_MAX : b;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} - {1'b0, b};
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = $signed(a) >>> sh;
            default: y = '0;
        endcase
        flags         = '0;
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
        flags[FLAG_Z] = ~|y;
        flags[FLAG_N] = y[MSB];
    end

endmodule

// File: rtl/alu_pipe_stage.sv
// rtl/alu_pipe_stage.sv - two-stage handshaked alu wrapper with sticky flags and op counter
// Optional ALU_PIPE_TAG_EN carries a TAG_W-bit tag alongside each command.
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
`ifdef ALU_PIPE_TAG_EN
    ,
    parameter int TAG_W   = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
`ifdef ALU_PIPE_TAG_EN
    input  logic [TAG_W-1:0]   in_tag,
    output logic [TAG_W-1:0]   out_tag,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic [FLAG_W-1:0]  out_flags,
    output logic [FLAG_W-1:0]  sticky_flags,
    input  logic               sticky_clr,
    output logic [COUNT_W-1:0] op_count
);

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [2:0]        s1_op;
    logic [WIDTH-1:0]  alu_y;
    logic [FLAG_W-1:0] alu_flags;
    logic              s2_free;
    logic              s1_move;
    logic              accept;
    logic              out_hs;
`ifdef ALU_PIPE_TAG_EN
    logic [TAG_W-1:0]  s1_tag;
`endif

    assign s2_free  = !out_valid || out_ready;
    assign s1_move  = s1_valid && s2_free;
    // Held low during reset so nothing is accepted into a stage being cleared.
    assign in_ready = !rst && (!s1_valid || s1_move);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .y     (alu_y),
        .flags (alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
`ifdef ALU_PIPE_TAG_EN
            s1_tag   <= '0;
`endif
        end else begin
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_op  <= in_op;
`ifdef ALU_PIPE_TAG_EN
                s1_tag <= in_tag;
`endif
            end
            s1_valid <= accept || (s1_valid && !s1_move);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_flags <= '0;
`ifdef ALU_PIPE_TAG_EN
            out_tag   <= '0;
`endif
        end else begin
            if (s1_move) begin
                out_y     <= alu_y;
                out_flags <= alu_flags;
`ifdef ALU_PIPE_TAG_EN
                out_tag   <= s1_tag;
`endif
            end
            out_valid <= s1_move || (out_valid && !out_ready);
        end
    end

    // A clear coinciding with a handshake keeps only that handshake's flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else begin
            if (sticky_clr) begin
                sticky_flags <= out_hs ? out_flags : '0;
            end else if (out_hs) begin
                sticky_flags <= sticky_flags | out_flags;
            end
            if (out_hs) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_stage.sv
// tb/tb_alu_pipe_stage.sv - scoreboard bench for alu_pipe_stage against an arithmetic reference model
module tb_alu_pipe_stage;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic [3:0]    out_flags;
    logic [3:0]    sticky_flags;
    logic          sticky_clr = 1'b0;
    logic [CW-1:0] op_count;
`ifdef ALU_PIPE_TAG_EN
    logic [3:0]    in_tag = '0;
    logic [3:0]    out_tag;
`endif

    always #5 clk = ~clk;

    alu_pipe_stage #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
`ifdef ALU_PIPE_TAG_EN
        .in_tag       (in_tag),
        .out_tag      (out_tag),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .op_count     (op_count)
    );

    typedef struct {
        logic [7:0] y;
        logic [3:0] f;
        int         acc;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         edge_cnt = 0;
    logic [3:0] m_sticky = '0;
    int         m_count = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic, result taken modulo 256.
    function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
        int sa, sb, sh, r;
        logic v, c;
        logic [7:0] y;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = (b > 7) ? 7 : b;
        r = 0; v = 1'b0; c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = a - b; c = (r < 0);   v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            default: r = sa >>> sh;
        endcase
        y = r[7:0];
        return {v, c, (y == 8'd0), y[7], y};
    endfunction

    always @(negedge clk) begin
        logic [11:0] r;
        logic        exp_valid;
        logic        hs;
        exp_t        e;
        #2;
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_sticky", sticky_flags, 0);
            check("rst_op_count", op_count, 0);
            q.delete();
            m_sticky = '0;
            m_count = 0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].acc < edge_cnt);
            check("out_valid", out_valid, exp_valid);
            check("in_ready", in_ready, (q.size() < 2) || out_ready);
            check("sticky_flags", sticky_flags, m_sticky);
            check("op_count", op_count, m_count);
            hs = 1'b0;
            e.f = '0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    hs = 1'b1;
                    check("out_y", out_y, e.y);
                    check("out_flags", out_flags, e.f);
                end
            end
            if (sticky_clr) m_sticky = hs ? e.f : 4'h0;
            else if (hs)    m_sticky = m_sticky | e.f;
            if (hs) m_count = (m_count + 1) % (1 << CW);
            if (in_valid && in_ready) begin
                r = ref_alu(in_a, in_b, in_op);
                e.y = r[7:0];
                e.f = r[11:8];
                e.acc = edge_cnt + 1;
                q.push_back(e);
            end
        end
    end

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic ordy, input logic clr,
                         output logic acc);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_op = op;
        out_ready = ordy; sticky_clr = clr;
`ifdef ALU_PIPE_TAG_EN
        in_tag = 4'($urandom);
`endif
        #1 acc = v && in_ready;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, a, b, op, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check("issue_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            cycle(1'b0, 8'h0, 8'h0, 3'd0, 1'b1, 1'b0, acc);
            #2;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic acc;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        // Latency: FF + 01 -> 00 with carry and zero.
        issue(8'hFF, 8'h01, 3'd0);
        drain();

        // Throughput: four back-to-back commands.
        cycle(1, 8'h01, 8'h02, 3'd0, 1, 0, acc); check("tp_acc0", acc, 1);
        cycle(1, 8'h05, 8'h03, 3'd1, 1, 0, acc); check("tp_acc1", acc, 1);
        cycle(1, 8'hFF, 8'h0F, 3'd4, 1, 0, acc); check("tp_acc2", acc, 1);
        cycle(1, 8'h01, 8'h09, 3'd5, 1, 0, acc); check("tp_acc3", acc, 1);
        drain();

        // Backpressure: two accepted, third refused until the consumer drains.
        cycle(1, 8'h10, 8'h20, 3'd0, 0, 0, acc); check("bp_acc0", acc, 1);
        cycle(1, 8'h30, 8'h05, 3'd1, 0, 0, acc); check("bp_acc1", acc, 1);
        cycle(1, 8'hAA, 8'h55, 3'd3, 0, 0, acc); check("bp_refused", acc, 0);
        cycle(1, 8'hAA, 8'h55, 3'd3, 0, 0, acc); check("bp_refused2", acc, 0);
        issue(8'hAA, 8'h55, 3'd3);
        drain();

        // Sticky flags: overflow then negative, then clear on the AND handshake.
        cycle(0, 8'h0, 8'h0, 3'd0, 1, 1, acc);
        cycle(1, 8'h80, 8'h01, 3'd1, 1, 0, acc);
        cycle(1, 8'hFF, 8'hFF, 3'd2, 1, 0, acc);
        drain();
        @(negedge clk); #1 check("sticky_1001", sticky_flags, 4'b1001);
        cycle(1, 8'h80, 8'h01, 3'd1, 1, 0, acc);
        cycle(1, 8'hFF, 8'hFF, 3'd2, 1, 0, acc);
        cycle(0, 8'h0, 8'h0, 3'd0, 1, 0, acc);
        cycle(0, 8'h0, 8'h0, 3'd0, 1, 1, acc);
        cycle(0, 8'h0, 8'h0, 3'd0, 1, 0, acc);
        @(negedge clk); #1 check("sticky_clr_set", sticky_flags, 4'b0001);

        // Reset mid-operation with both stages full.
        cycle(1, 8'h12, 8'h34, 3'd0, 0, 0, acc);
        cycle(1, 8'h56, 8'h07, 3'd7, 0, 0, acc);
        cycle(0, 8'h0, 8'h0, 3'd0, 0, 0, acc);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_sticky", sticky_flags, 0);
        check("async_op_count", op_count, 0);
        check("async_in_ready", in_ready, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        cycle(0, 8'h0, 8'h0, 3'd0, 1, 0, acc);
        check("post_rst_in_ready", in_ready, 1);

        // Randomized traffic with random backpressure and clears.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom_range(0, 12)),
                  3'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), acc);
        end
        drain();

        // Counter wrap: 17 handshakes after reset on a 4-bit counter.
        @(negedge clk); #3 rst = 1'b1;
        @(negedge clk); #3 rst = 1'b0;
        for (int i = 0; i < 17; i++) issue(8'($urandom), 8'($urandom), 3'($urandom));
        drain();
        @(negedge clk); #1 check("count_wrap", op_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
